// File: rtl/ripple_cla16_adder.sv
// 16-bit adder from four 4-bit lookahead groups with inter-group ripple; RIPPLE_CLA16_SUB_EN adds a sub port (A - B).
// Latency 1 clk (registered Output/c_out/ready2), throughput 1/clk; no backpressure, en gates capture.
module ripple_cla16_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        c_in,
`ifdef RIPPLE_CLA16_SUB_EN
  input  logic        sub,
`endif
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Output,
  output logic        c_out,
  output logic        ready2
);

  logic [15:0] b_eff;
  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [15:0] sum;

`ifdef RIPPLE_CLA16_SUB_EN
  logic [15:0] b_neg;
  assign b_neg = ~B + 16'd1;
  assign b_eff = sub ? b_neg : B;
`else
  assign b_eff = B;
`endif

  assign g    = A & b_eff;
  assign p    = A ^ b_eff;
  assign c[0] = c_in;

  // Full lookahead inside each group; only c[4k] ripples between groups.
  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic       ci;

    assign gg = g[4*k +: 4];
    assign pp = p[4*k +: 4];
    assign ci = c[4*k];

    assign c[4*k+1] = gg[0] | (pp[0] & ci);
    assign c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    assign c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                    | (pp[2] & pp[1] & pp[0] & ci);
    assign c[4*k+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                    | (pp[3] & pp[2] & pp[1] & gg[0])
                    | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
  end

  assign sum = p ^ c[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Output <= 16'h0000;
      c_out  <= 1'b0;
      ready2 <= 1'b0;
    end else if (en) begin
      Output <= sum;
      c_out  <= c[16];
      ready2 <= 1'b1;
    end else begin
      ready2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ripple_cla16_adder.sv
// Self-checking bench: directed corner vectors plus random stimulus against an arithmetic reference model.
module tb_ripple_cla16_adder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        c_in;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Output;
  logic        c_out;
  logic        ready2;
`ifdef RIPPLE_CLA16_SUB_EN
  logic        sub;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_out;
  logic        exp_c;
  logic        exp_rdy;

  ripple_cla16_adder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .c_in   (c_in),
`ifdef RIPPLE_CLA16_SUB_EN
    .sub    (sub),
`endif
    .A      (A),
    .B      (B),
    .Output (Output),
    .c_out  (c_out),
    .ready2 (ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one operand set, clock it, update the model, then compare.
  task automatic step(input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic e, input logic s);
    logic [15:0] bb;
    logic [16:0] t;
    @(negedge clk);
    A    = a;
    B    = b;
    c_in = ci;
    en   = e;
`ifdef RIPPLE_CLA16_SUB_EN
    sub  = s;
`endif
    @(posedge clk);
    bb = s ? 16'((17'h10000 - {1'b0, b}) % 17'h10000) : b;
    if (e) begin
      t       = {1'b0, a} + {1'b0, bb} + {16'd0, ci};
      exp_out = t[15:0];
      exp_c   = t[16];
      exp_rdy = 1'b1;
    end else begin
      exp_rdy = 1'b0;
    end
    #1;
    chk("out",   {16'd0, Output}, {16'd0, exp_out});
    chk("c_out", {31'd0, c_out},  {31'd0, exp_c});
    chk("ready", {31'd0, ready2}, {31'd0, exp_rdy});
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    rst_n = 1'b1;
    en    = 1'b0;
    c_in  = 1'b0;
    A     = 16'h0;
    B     = 16'h0;
`ifdef RIPPLE_CLA16_SUB_EN
    sub   = 1'b0;
`endif
    exp_out = 16'h0;
    exp_c   = 1'b0;
    exp_rdy = 1'b0;

    // Mid-cycle asynchronous reset with an active enable and live operands.
    @(negedge clk);
    en = 1'b1; A = 16'hFFFF; B = 16'h0001;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out",   {16'd0, Output}, 32'h0);
    chk("rst_c",     {31'd0, c_out},  32'h0);
    chk("rst_ready", {31'd0, ready2}, 32'h0);
    @(posedge clk); #1;
    chk("rst_hold_out",   {16'd0, Output}, 32'h0);
    chk("rst_hold_ready", {31'd0, ready2}, 32'h0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    step(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("post_rst_out", {16'd0, Output}, 32'h0);

    // Carries across group boundaries, carry-in and wrap.
    step(16'h000F, 16'h0001, 1'b0, 1'b1, 1'b0);
    chk("grp0_out", {16'd0, Output}, 32'h0010);
    step(16'h00FF, 16'hFF01, 1'b0, 1'b1, 1'b0);
    chk("grp_all_out", {16'd0, Output}, 32'h0000);
    chk("grp_all_c",   {31'd0, c_out},  32'h1);
    step(16'h1234, 16'h4321, 1'b1, 1'b1, 1'b0);
    chk("cin_out", {16'd0, Output}, 32'h5556);
    step(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    chk("wrap_out", {16'd0, Output}, 32'h0000);
    chk("wrap_c",   {31'd0, c_out},  32'h1);
    step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    chk("max_out", {16'd0, Output}, 32'hFFFF);
    chk("max_c",   {31'd0, c_out},  32'h1);

    // Enable hold: result and carry stay, ready drops.
    step(16'h000F, 16'h0001, 1'b0, 1'b1, 1'b0);
    step(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    chk("hold_out",   {16'd0, Output}, 32'h0010);
    chk("hold_c",     {31'd0, c_out},  32'h0);
    chk("hold_ready", {31'd0, ready2}, 32'h0);

    // Accumulation loop from zero, feeding the expected result back as A.
    step(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(exp_out, 16'h0003, 1'b0, 1'b1, 1'b0);
      chk("acc_out", {16'd0, Output}, 32'(3 * i));
    end

`ifdef RIPPLE_CLA16_SUB_EN
    step(16'h0005, 16'h0003, 1'b0, 1'b1, 1'b1);
    chk("sub_pos_out", {16'd0, Output}, 32'h0002);
    chk("sub_pos_c",   {31'd0, c_out},  32'h1);
    step(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1);
    chk("sub_neg_out", {16'd0, Output}, 32'hFFFE);
    chk("sub_neg_c",   {31'd0, c_out},  32'h0);
    step(16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("sub_zero_out", {16'd0, Output}, 32'h1234);
    chk("sub_zero_c",   {31'd0, c_out},  32'h0);
    step(16'h0000, 16'h8000, 1'b0, 1'b1, 1'b1);
    chk("sub_min_out", {16'd0, Output}, 32'h8000);
`endif

    // Random operands, carry-in and enable.
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
`ifdef RIPPLE_CLA16_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      step(ra, rb, 1'($urandom), ($urandom_range(0, 3) != 0), rs);
    end

    // Second reset mid-run discards the held result.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_out",   {16'd0, Output}, 32'h0);
    chk("rst2_ready", {31'd0, ready2}, 32'h0);
    exp_out = 16'h0;
    exp_c   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ripple_cla16_adder.md
Name: ripple_cla16_adder

Overview:
- 16-bit adder built from four 4-bit carry-lookahead (CLA) groups, with the carry rippling from one group to the next.
- Result, carry-out and a ready flag are registered.
- The Booth multiplier datapath uses it to accumulate partial products: c_in=0, en held high.
- Optional two's-complement operand path turns it into an adder/subtractor.

Parameters:
- none (width fixed at 16 bits, group size fixed at 4 bits)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; result registered on clk rising edge while high
- c_in  input  1  carry into bit 0
- A  input  16  operand A, unsigned or two's-complement
- B  input  16  operand B, unsigned or two's-complement
- Output  output  16  registered sum, bits [15:0]
- c_out  output  1  registered carry out of bit 15
- ready2  output  1  registered result-valid flag

Behaviour:
- Reset: rst_n=0 immediately forces Output=0x0000, c_out=0, ready2=0, independent of clk and en. Reset mid-operation discards any pending result.
- Combinational core, bit i:
  - g_i = A_i & B_i
  - p_i = A_i ^ B_i
- Each 4-bit group computes its internal carries c1..c4 with full lookahead equations from g, p and the group carry-in. No internal ripple inside a group.
- Group 0 carry-in = c_in. Group k carry-in = carry-out c4 of group k-1. Group 3 carry-out = c_out.
- Sum bit s_i = p_i ^ c_i.
- Arithmetic: {c_out, Output} = A + B + c_in as a 17-bit unsigned result. Output wraps modulo 2^16. No overflow flag; signed overflow is the user's concern.
- Clock edge with en=1: Output <= sum, c_out <= carry, ready2 <= 1. Latency is 1 clock from operand presentation to valid Output.
- Clock edge with en=0: Output and c_out hold their last values; ready2 <= 0.
- Continuous operation: with en held high, a new result is registered every cycle (throughput 1/clk) and ready2 stays 1.
- Operands changing while en=1: the value sampled at the edge wins. No internal operand latching beyond the output register.
- rst_n deassertion: takes effect at the next rising clk edge. First valid ready2 appears one edge after en is sampled high.

Optional Feature:
- Macro: RIPPLE_CLA16_SUB_EN.
- When defined:
  - Adds input port sub (1 bit).
  - A two's-complement unit computes Bn = (~B + 1) mod 2^16. Mappings: 0x0000 -> 0x0000, 0x8000 -> 0x8000.
  - When sub=1, Bn replaces B at the CLA inputs: {c_out, Output} = A + Bn + c_in. For B=0x0000, c_out is the plain carry of A + 0 + c_in.
  - When sub=0, behaviour is identical to the base design.
- When not defined: no sub port and no complement logic; pure adder.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with en=1 and A=0xFFFF -> Output=0x0000, c_out=0, ready2=0 immediately. Values stay there until rst_n=1 and the next en edge.
- Carry across group boundaries:
  - A=0x000F, B=0x0001, c_in=0, en=1 -> one edge later Output=0x0010, c_out=0, ready2=1.
  - A=0x00FF, B=0xFF01 -> Output=0x0000, c_out=1.
- Carry-in and wrap:
  - A=0x1234, B=0x4321, c_in=1 -> Output=0x5556, c_out=0.
  - A=0xFFFF, B=0x0001, c_in=0 -> Output=0x0000, c_out=1.
  - A=0xFFFF, B=0xFFFF, c_in=1 -> Output=0xFFFF, c_out=1.
- Enable hold: register 0x0010, then drop en and change A=0x1111, B=0x2222 -> Output stays 0x0010, c_out holds, ready2=0 after the next edge.
- Accumulation loop: feed Output back to A with B=0x0003 and en high for 4 cycles from 0 -> Output sequence 0x0003, 0x0006, 0x0009, 0x000C; ready2 stays 1.
- With RIPPLE_CLA16_SUB_EN:
  - A=0x0005, B=0x0003, sub=1 -> Output=0x0002, c_out=1.
  - A=0x0003, B=0x0005, sub=1 -> Output=0xFFFE, c_out=0.
  - A=0x1234, B=0x0000, sub=1 -> Output=0x1234, c_out=0.
